// File: rtl/responder_pkg.sv
// responder_pkg: shared state codes, player encoding and preset limits for the quiz responder
package responder_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    LOCKED  = 3'd2,
    TIMEOUT = 3'd3,
    FOUL    = 3'd4
  } state_t;
  localparam logic [2:0] PLAYER_NONE = 3'd0;
  localparam int PRESET_MIN  = 10;
  localparam int PRESET_MAX  = 90;
  localparam int PRESET_STEP = 10;
endpackage

// File: rtl/responder_arbiter_tick_gen.sv
// tick_gen: one-cycle strobe every MAX+1 enabled cycles, restartable by sclr
//   clk, rstn (async active-low), en (count enable), sclr (sync restart), tick (strobe)
module tick_gen #(
  parameter int MAX = 49_999_999
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic sclr,
  output logic tick
);
  localparam int W = MAX > 0 ? $clog2(MAX + 1) : 1;
  logic [W-1:0] cnt;
  assign tick = en && !sclr && cnt == W'(MAX);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (sclr || !en) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/responder_arbiter.sv
// responder_arbiter: quiz responder FSM - arming, first-press latch, foul detect, countdown, buzz
//   in : clk, rstn (async active-low), key_deb[3:0], start, clr, set_time (levels, rising edge = event)
//   out: state_o[2:0], winner[2:0], foul, timeout, remain[6:0] (seconds), buzz
module responder_arbiter
  import responder_pkg::*;
#(
  parameter int TICK_MAX   = 49_999_999,
  parameter int BUZZ_CYC   = 24_999_999,
  parameter int PRESET_DEF = 30
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key_deb,
  input  logic       start,
  input  logic       clr,
  input  logic       set_time,
  output logic [2:0] state_o,
  output logic [2:0] winner,
  output logic       foul,
  output logic       timeout,
  output logic [6:0] remain,
  output logic       buzz
);
  localparam int BW = BUZZ_CYC > 0 ? $clog2(BUZZ_CYC + 1) : 1;
  state_t state;
  logic [3:0] key_prev, kev;
  logic start_prev, clr_prev, set_prev, sev, cev, tev, tick;
  logic [6:0] preset, next_preset;
  logic [2:0] pick;
  logic [BW-1:0] bcnt;
  // history regs reset to 1 so a level already high at reset release is not an event
  assign kev = key_deb & ~key_prev;
  assign sev = start & ~start_prev;
  assign cev = clr & ~clr_prev;
  assign tev = set_time & ~set_prev;
  assign pick = kev[0] ? 3'd1 : kev[1] ? 3'd2 : kev[2] ? 3'd3 : 3'd4;
  assign next_preset = preset >= 7'(PRESET_MAX) ? 7'(PRESET_MIN) : preset + 7'(PRESET_STEP);
  assign state_o = state;
  // the second counter only runs while ARMED, so it restarts from zero on every arming
  tick_gen #(.MAX(TICK_MAX)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .en   (state == ARMED),
    .sclr (cev || state != ARMED),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      winner     <= PLAYER_NONE;
      foul       <= 1'b0;
      timeout    <= 1'b0;
      buzz       <= 1'b0;
      bcnt       <= '0;
      preset     <= 7'(PRESET_DEF);
      remain     <= 7'(PRESET_DEF);
      key_prev   <= '1;
      start_prev <= 1'b1;
      clr_prev   <= 1'b1;
      set_prev   <= 1'b1;
    end else begin
      key_prev   <= key_deb;
      start_prev <= start;
      clr_prev   <= clr;
      set_prev   <= set_time;
      if (buzz) begin
        bcnt <= bcnt + BW'(1);
        if (bcnt == BW'(BUZZ_CYC)) buzz <= 1'b0;
      end
      if (cev) begin
        state   <= IDLE;
        winner  <= PLAYER_NONE;
        foul    <= 1'b0;
        timeout <= 1'b0;
        buzz    <= 1'b0;
        remain  <= preset;
      end else begin
        case (state)
          IDLE:
            if (|kev) begin
              state  <= FOUL;
              foul   <= 1'b1;
              winner <= pick;
              buzz   <= 1'b1;
              bcnt   <= '0;
            end else if (sev) begin
              state  <= ARMED;
              remain <= preset;
            end else if (tev) begin
              preset <= next_preset;
              remain <= next_preset;
            end
          ARMED:
            if (|kev) begin
              state  <= LOCKED;
              winner <= pick;
              buzz   <= 1'b1;
              bcnt   <= '0;
            end else if (tick && remain != '0) begin
              remain <= remain - 7'd1;
              if (remain == 7'd1) begin
                state   <= TIMEOUT;
                timeout <= 1'b1;
                buzz    <= 1'b1;
                bcnt    <= '0;
              end
            end
          default: ;
        endcase
      end
    end
  end
endmodule
